uart_tx_core: RTL

Synthesizable UART transmitter that accepts bytes over a valid/ready interface, buffers them, and serialises them onto `txd`. Frame format is run-time configurable:

- 5–8 data bits
- optional even/odd parity
- 1 or 2 stop bits
- 16-bit baud divisor

It sits between the register/bus side of the UART peripheral and the pad. In simulation its `txd` drives the bench UART monitor's `rxd`, so bit timing and the parity convention match that monitor exactly.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx_core.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state type and frame constants for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } tx_state_t;

   localparam int unsigned DATA_BITS_BASE = 5;
   localparam int unsigned DIV_W          = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full/empty
// and the level fall straight out of the pointer difference.
module uart_tx_fifo #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [7:0]    i_data,
   output logic [7:0]    o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_level
);

   localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_push;
   logic        w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rptr[AW-1:0]];
   assign o_level = r_wptr - r_rptr;
   assign o_full  = (o_level == LVL_FULL);
   assign o_empty = (r_wptr == r_rptr);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte input, buffered, serialised on txd.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              cfg_tx_en,
   input  logic [1:0]        cfg_data_bits,
   input  logic              cfg_stop_bits,
   input  logic              cfg_parity_en,
   input  logic              cfg_even_parity,
   input  logic [DIV_W-1:0]  cfg_divisor,
   input  logic [7:0]        tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic [LVL_W-1:0]  tx_level
);

   tx_state_t         r_state;
   tx_state_t         w_next_state;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_can_start;
   logic              w_cnt_zero;
   logic              w_last_bit;
   logic              w_txd;
   logic [7:0]        w_fifo_data;
   logic [7:0]        w_mask;
   logic [DIV_W:0]    r_cnt;
   logic [7:0]        r_shift;
   logic [2:0]        r_bit_idx;
   logic [2:0]        r_last_idx;
   logic              r_par;
   logic              r_frm_par_en;
   logic              r_frm_even;
   logic              r_frm_stop2;
   logic [DIV_W-1:0]  r_frm_div;
   logic              r_txd;

   assign w_push   = tx_valid && !w_full;
   assign tx_ready = !w_full;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (mclk),
      .i_rst   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (tx_data),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (tx_level)
   );
`else
   logic       r_hold_vld;
   logic [7:0] r_hold;

   // Push only happens when empty and pop only when full, so they never collide.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_hold_vld <= 1'b0;
         r_hold     <= '0;
      end else if (w_push) begin
         r_hold_vld <= 1'b1;
         r_hold     <= tx_data;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end

   assign w_full      = r_hold_vld;
   assign w_empty     = !r_hold_vld;
   assign w_fifo_data = r_hold;
   assign tx_level    = {{(LVL_W - 1){1'b0}}, r_hold_vld};
`endif

   assign w_can_start = cfg_tx_en && !w_empty;
   assign w_cnt_zero  = (r_cnt == '0);
   assign w_last_bit  = (r_bit_idx == r_last_idx);
   assign w_mask      = 8'hFF >> (2'd3 - cfg_data_bits);

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_txd        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_can_start) begin
               w_next_state = START;
               w_pop        = 1'b1;
            end
         end
         START: begin
            w_txd = 1'b0;
            if (w_cnt_zero) w_next_state = DATA;
         end
         DATA: begin
            w_txd = r_shift[0];
            if (w_cnt_zero && w_last_bit) w_next_state = r_frm_par_en ? PARITY : STOP1;
         end
         PARITY: begin
            w_txd = r_frm_even ? r_par : !r_par;
            if (w_cnt_zero) w_next_state = STOP1;
         end
         STOP1: begin
            if (w_cnt_zero) begin
               if (r_frm_stop2) begin
                  w_next_state = STOP2;
               end else if (w_can_start) begin
                  w_next_state = START;
                  w_pop        = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         STOP2: begin
            if (w_cnt_zero) begin
               if (w_can_start) begin
                  w_next_state = START;
                  w_pop        = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // A pop always coincides with START entry, so it reloads from the live config.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_txd        <= 1'b1;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_bit_idx    <= '0;
         r_last_idx   <= '0;
         r_frm_par_en <= 1'b0;
         r_frm_even   <= 1'b0;
         r_frm_stop2  <= 1'b0;
         r_frm_div    <= '0;
      end else begin
         r_txd <= w_txd;
         if (w_pop) begin
            r_cnt        <= {cfg_divisor, 1'b1};
            r_shift      <= w_fifo_data & w_mask;
            r_par        <= ^(w_fifo_data & w_mask);
            r_bit_idx    <= '0;
            r_last_idx   <= 3'(cfg_data_bits) + 3'(DATA_BITS_BASE - 1);
            r_frm_par_en <= cfg_parity_en;
            r_frm_even   <= cfg_even_parity;
            r_frm_stop2  <= cfg_stop_bits;
            r_frm_div    <= cfg_divisor;
         end else if (w_cnt_zero) begin
            r_cnt <= {r_frm_div, 1'b1};
            if (r_state == DATA) begin
               r_shift   <= r_shift >> 1;
               r_bit_idx <= r_bit_idx + 1'b1;
            end
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign txd     = r_txd;
   assign tx_busy = (r_state != IDLE) || !w_empty;

endmodule
